// File: rtl/gps_capture_ctrl.sv
// Capture sequencer for the 1-bit GPS sample shift buffer: clear, gated fill of DEPTH
// samples, freeze when full, then a valid/ready walk of the read index for the consumer.
module gps_capture_ctrl #(
    parameter int DEPTH = 81,
    parameter int CW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          sample_en,
    output logic          buf_clr,
    output logic          buf_shift_en,
    output logic [CW-1:0] fill_count,
    output logic          busy,
    output logic          done,
    input  logic          rd_start,
    output logic [CW-1:0] rd_addr,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_last
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FILL  = 3'd2,
        S_FULL  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_t        state_q, state_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [CW-1:0] rd_addr_q, rd_addr_d;
    logic          abort_act_s;

    assign abort_act_s = abort && (state_q != S_IDLE);

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fill_q    <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Next-state logic; abort outranks every command and strobe
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        rd_addr_d = rd_addr_q;
        if (abort_act_s) begin
            state_d   = S_IDLE;
            rd_addr_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CLEAR;
                        fill_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    state_d = S_FILL;
                end
                S_FILL: begin
                    if (sample_en) begin
                        fill_d = fill_q + CW'(1);
                        if (fill_q == LAST_IDX) begin
                            state_d = S_FULL;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        state_d = S_FILL;
                    end
                end
                S_FULL: begin
                    if (rd_start) begin
                        state_d   = S_READ;
                        rd_addr_d = '0;
                    end else begin
                        state_d = S_FULL;
                    end
                end
                S_READ: begin
                    if (rd_ready) begin
                        if (rd_addr_q == LAST_IDX) begin
                            state_d   = S_IDLE;
                            rd_addr_d = '0;
                        end else begin
                            rd_addr_d = rd_addr_q + CW'(1);
                        end
                    end else begin
                        rd_addr_d = rd_addr_q;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    rd_addr_d = '0;
                end
            endcase
        end
    end

    // Buffer controls are combinational so the buffer latches on the strobe's own edge
    always_comb begin
        buf_clr      = 1'b0;
        buf_shift_en = 1'b0;
        if (!abort_act_s) begin
            buf_clr      = (state_q == S_CLEAR);
            buf_shift_en = (state_q == S_FILL) && sample_en;
        end else begin
            buf_clr      = 1'b0;
            buf_shift_en = 1'b0;
        end
    end

    assign fill_count = fill_q;
    assign rd_addr    = rd_addr_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FULL);
    assign rd_valid   = (state_q == S_READ);
    assign rd_last    = (state_q == S_READ) && (rd_addr_q == LAST_IDX);

    logic unused_s;
    assign unused_s = ^FULL_CNT;

endmodule

// File: tb/tb_gps_capture_ctrl.sv
// Directed scoreboard bench for gps_capture_ctrl: capture, sparse strobes, readout
// backpressure, ignored commands, abort and reset mid-readout.
module tb_gps_capture_ctrl;

    localparam int DEPTH = 81;
    localparam int CW    = 7;

    logic          clk = 1'b0;
    logic          rst, start, abort, sample_en, rd_start, rd_ready;
    logic          buf_clr, buf_shift_en, busy, done, rd_valid, rd_last;
    logic [CW-1:0] fill_count, rd_addr;

    int vectors     = 0;
    int miscompares = 0;
    int exp_fill    = 0;
    int fill_q[$];
    int rd_q[$];

    gps_capture_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .sample_en(sample_en),
        .buf_clr(buf_clr), .buf_shift_en(buf_shift_en), .fill_count(fill_count),
        .busy(busy), .done(done), .rd_start(rd_start), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_clr"}, buf_clr, 0);
        chk({tag, "_shift"}, buf_shift_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rdv"}, rd_valid, 0);
        chk({tag, "_rdl"}, rd_last, 0);
        chk({tag, "_rda"}, rd_addr, 0);
    endtask

    // start from IDLE; sample_en during CLEAR must be ignored
    task automatic do_start();
        start = 1'b1;
        nxt();
        start     = 1'b0;
        sample_en = 1'b1;
        @(negedge clk);
        chk("clr_pulse", buf_clr, 1);
        chk("clr_shift", buf_shift_en, 0);
        chk("clr_fill", fill_count, 0);
        chk("clr_busy", busy, 1);
        nxt();
        sample_en = 1'b0;
        exp_fill  = 0;
        chk("clr_ignored_strobe", fill_count, 0);
    endtask

    task automatic fill_n(input int n);
        for (int i = 0; i < n; i++) begin
            sample_en = 1'b1;
            @(negedge clk);
            chk("fill_shift", buf_shift_en, 1);
            chk("fill_no_clr", buf_clr, 0);
            fill_q.push_back(exp_fill + 1);
            exp_fill++;
            nxt();
            chk("fill_count", fill_count, fill_q.pop_front());
        end
        sample_en = 1'b0;
    endtask

    initial begin
        int  cnt;
        bit  injected;
        bit  se;
        logic [3:0] pat;
        pat = 4'b1001;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sample_en = 1'b0;
        rd_start = 1'b0; rd_ready = 1'b0;
        nxt(); nxt();
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_fill", fill_count, 0);
        nxt();

        // basic capture, strobe every cycle
        do_start();
        fill_n(DEPTH);
        sample_en = 1'b1;
        @(negedge clk);
        chk("full_done", done, 1);
        chk("full_frozen_shift", buf_shift_en, 0);
        chk("full_fill", fill_count, DEPTH);
        nxt();
        sample_en = 1'b0;
        chk("full_fill_hold", fill_count, DEPTH);

        // readout with rd_ready pattern 1,0,0,1
        rd_start = 1'b1;
        nxt();
        rd_start = 1'b0;
        for (int a = 0; a < DEPTH; a++) rd_q.push_back(a);
        for (int k = 0; k < 600 && rd_q.size() > 0; k++) begin
            rd_ready = pat[k % 4];
            @(negedge clk);
            chk("rd_valid", rd_valid, 1);
            chk("rd_addr", rd_addr, rd_q[0]);
            chk("rd_last", rd_last, (rd_q[0] == DEPTH - 1));
            if (rd_ready) void'(rd_q.pop_front());
            nxt();
        end
        chk("rd_timeout", rd_q.size(), 0);
        rd_ready = 1'b0;
        chk("rd_end_busy", busy, 0);
        chk("rd_end_valid", rd_valid, 0);
        chk("rd_end_addr", rd_addr, 0);
        chk("rd_end_fill", fill_count, DEPTH);

        // sparse strobes with ignored start/rd_start at fill_count 40
        do_start();
        injected = 1'b0;
        cnt = 0;
        for (int c = 0; c < 600 && exp_fill < DEPTH; c++) begin
            se = (c % 3 == 2);
            sample_en = se;
            if (exp_fill == 40 && !se && !injected) begin
                start = 1'b1; rd_start = 1'b1; injected = 1'b1;
            end
            @(negedge clk);
            chk("sp_shift", buf_shift_en, se);
            chk("sp_clr", buf_clr, 0);
            chk("sp_rdv", rd_valid, 0);
            chk("sp_done", done, 0);
            nxt();
            start = 1'b0; rd_start = 1'b0; sample_en = 1'b0;
            if (se) exp_fill++;
            cnt++;
            chk("sp_fill", fill_count, exp_fill);
        end
        chk("sp_injected", injected, 1);
        chk("sp_done_end", done, 1);
        chk("sp_cycles", cnt, 3 * DEPTH);

        // readout with rd_ready held high lasts DEPTH cycles
        rd_start = 1'b1; rd_ready = 1'b1;
        nxt();
        rd_start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!rd_valid) break;
            cnt++;
            nxt();
        end
        rd_ready = 1'b0;
        chk("rd_len", cnt, DEPTH);
        chk("rd_len_idle", busy, 0);

        // abort mid-fill at 50 with a strobe in the abort cycle
        do_start();
        fill_n(50);
        sample_en = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("ab_shift", buf_shift_en, 0);
        chk("ab_clr", buf_clr, 0);
        nxt();
        abort = 1'b0; sample_en = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_fill", fill_count, 50);
        abort = 1'b1;
        nxt();
        abort = 1'b0;
        chk("ab_idle_busy", busy, 0);
        chk("ab_idle_fill", fill_count, 50);
        do_start();

        // reset mid-readout at rd_addr 30
        fill_n(DEPTH);
        rd_start = 1'b1; rd_ready = 1'b1;
        nxt();
        rd_start = 1'b0;
        repeat (30) nxt();
        @(negedge clk);
        chk("rs_addr30", rd_addr, 30);
        rst = 1'b1;
        nxt();
        rst = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        chk_idle_outputs("rs");
        chk("rs_fill", fill_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
